// File: rtl/uart_pkg.sv
// Shared types and line levels for the 8N1 transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with a registered full flag; head is visible on dout.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_n;
  logic             do_push;
  logic             do_pop;

  // full is the pre-edge value, so a write racing a pop while full is dropped
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (do_push && !do_pop) begin
      count_n = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_n = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmit-only UART: byte FIFO feeding a divisor-timed shift engine.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       wdata,
  input  logic             we,
  input  logic [DIV_W-1:0] bdiv,
  output logic             tx,
  output logic             busy,
  output logic             full
);

  localparam int               CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int               BIT_W    = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  state_t               state;
  state_t               state_n;
  logic [DIV_W-1:0]     div_cnt;
  logic [DIV_W-1:0]     div_n;
  logic [DIV_W-1:0]     bdiv_lat;
  logic [DIV_W-1:0]     bdiv_n;
  logic [DIV_W-1:0]     bdiv_eff;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_n;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_n;
  logic [DATA_BITS-1:0] head;
  logic [CNT_W-1:0]     count;
  logic                 tx_n;
  logic                 load;
  logic                 wrap;
  logic                 empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (we),
    .pop   (load),
    .din   (wdata),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bdiv_eff = (bdiv == '0) ? DIV_W'(1) : bdiv;
  assign wrap     = (div_cnt == bdiv_lat - 1'b1);
  assign busy     = (count != '0) || (state != IDLE);

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    bdiv_n  = bdiv_lat;
    tx_n    = tx;
    load    = 1'b0;
    case (state)
      IDLE: begin
        tx_n = IDLE_LEVEL;
        load = !empty;
      end
      START: begin
        if (wrap) begin
          state_n = DATA;
          tx_n    = shift[0];
        end
      end
      DATA: begin
        if (wrap) begin
          if (bit_cnt == LAST_BIT) begin
            state_n = STOP;
            tx_n    = STOP_LEVEL;
          end else begin
            bit_n   = bit_cnt + 1'b1;
            shift_n = shift >> 1;
            tx_n    = shift[1];
          end
        end
      end
      STOP: begin
        if (wrap) begin
          if (!empty) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            tx_n    = IDLE_LEVEL;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE) begin
      div_n = wrap ? '0 : div_cnt + 1'b1;
    end
    // Popping from IDLE or the last stop cycle starts a frame with no idle gap
    if (load) begin
      state_n = START;
      shift_n = head;
      bdiv_n  = bdiv_eff;
      bit_n   = '0;
      div_n   = '0;
      tx_n    = START_LEVEL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx      <= IDLE_LEVEL;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      tx      <= tx_n;
    end
  end

  always_ff @(posedge clk) begin
    shift    <= shift_n;
    bdiv_lat <= bdiv_n;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame-timing model, independent line receiver, literal checks.
module tb_uart_tx;

  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             we    = 1'b0;
  logic [7:0]       wdata = 8'h00;
  logic [DIV_W-1:0] bdiv  = 16'd434;
  logic             tx;
  logic             busy;
  logic             full;

  uart_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wdata (wdata),
    .we    (we),
    .bdiv  (bdiv),
    .tx    (tx),
    .busy  (busy),
    .full  (full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame model: a frame is a start edge, a period and a byte; the line level
  // follows from elapsed time alone.
  logic [7:0] mq[$];
  bit         m_act  = 1'b0;
  int         m_s    = 0;
  int         m_p    = 1;
  logic [7:0] m_byte = 8'h00;
  int         cyc    = 0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    bit done;
    bit popm;
    bit full_pre;
    cyc++;
    if (reset) begin
      mq.delete();
      m_act  = 1'b0;
      chk_en = 1'b1;
    end else begin
      full_pre = (mq.size() == FIFO_DEPTH);
      done     = m_act && ((cyc - m_s) == 10 * m_p);
      popm     = (mq.size() != 0) && (!m_act || done);
      if (popm) begin
        m_byte = mq.pop_front();
        m_s    = cyc;
        m_p    = (bdiv == '0) ? 1 : int'(bdiv);
        m_act  = 1'b1;
      end else if (done) begin
        m_act = 1'b0;
      end
      if (we && !full_pre) mq.push_back(wdata);
    end
  end

  function automatic logic model_tx();
    int idx;
    if (!m_act) return 1'b1;
    idx = (cyc - m_s) / m_p;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    logic [2:0] exp_v;
    if (chk_en) begin
      exp_v = {model_tx(), (mq.size() != 0) || m_act, mq.size() == FIFO_DEPTH};
      check($sformatf("cycle%0d tx_busy_full", cyc), 32'({tx, busy, full}), 32'(exp_v));
    end
  end

  // Independent receiver sampling mid-bit at a known period
  logic [7:0] rx_q[$];
  int         rx_frames = 0;
  bit         rx_en     = 1'b0;
  int         rx_per    = 434;

  initial forever begin
    logic [7:0] b;
    @(negedge clk);
    if (rx_en && tx === 1'b0) begin
      repeat (rx_per / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (rx_per) @(negedge clk);
        b[i] = tx;
      end
      repeat (rx_per) @(negedge clk);
      check("rx_stop_bit", 32'(tx), 32'd1);
      rx_q.push_back(b);
      rx_frames++;
    end
  end

  task automatic rx_expect(input string name, input logic [7:0] exp);
    logic [31:0] act = 32'hFFFF_FFFF;
    if (rx_q.size() > 0) act = 32'(rx_q.pop_front());
    check(name, act, 32'(exp));
  endtask

  task automatic write_byte(input logic [7:0] b);
    we    = 1'b1;
    wdata = b;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #990000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         k;
    int         s;
    int         bad;
    logic [0:9] a_bits = 10'b0100000101;
    logic [7:0] burst [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Reset and idle line
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (1000) @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_full", 32'(full), 32'd0);

    // Single 'A' at 434 cycles per bit
    bdiv   = 16'd434;
    rx_per = 434;
    rx_en  = 1'b1;
    write_byte(8'h41);
    k = cyc;
    for (int i = 0; i < 10; i++) begin
      wait_until(k + 1 + i * 434 + 217);
      check($sformatf("A_bit%0d", i), 32'(tx), 32'(a_bits[i]));
    end
    wait_until(k + 4340);
    check("A_busy_last", 32'(busy), 32'd1);
    wait_until(k + 4341);
    check("A_busy_drop", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("A_rx_frames", 32'(rx_frames), 32'd1);
    rx_expect("A_rx_byte", 8'h41);

    // we held high from reset release
    rx_frames = 0;
    rx_q.delete();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    we    = 1'b1;
    wdata = 8'h41;
    k = cyc;
    wait_until(k + 6);
    check("stream_full", 32'(full), 32'd1);
    wait_until(k + 50000);
    check("stream_frames", 32'(rx_frames), 32'd11);
    for (int i = 0; i < 11; i++) rx_expect($sformatf("stream_byte%0d", i), 8'h41);
    we    = 1'b0;
    rx_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4400) @(negedge clk);
    rx_q.delete();
    rx_frames = 0;

    // Fast divisor, back-to-back 00 and FF, then an overfull burst
    bdiv   = 16'd4;
    rx_per = 4;
    rx_en  = 1'b1;
    write_byte(8'h00);
    write_byte(8'hFF);
    wait_idle(200, "pair_idle");
    repeat (4) @(negedge clk);
    check("pair_frames", 32'(rx_frames), 32'd2);
    rx_expect("pair_byte0", 8'h00);
    rx_expect("pair_byte1", 8'hFF);
    rx_frames = 0;
    for (int i = 0; i < 6; i++) write_byte(burst[i]);
    check("burst_full", 32'(full), 32'd1);
    wait_idle(400, "burst_idle");
    repeat (4) @(negedge clk);
    check("burst_frames", 32'(rx_frames), 32'd5);
    for (int i = 0; i < 5; i++) rx_expect($sformatf("burst_byte%0d", i), burst[i]);

    // Divisor change during a frame only affects the next frame
    rx_en = 1'b0;
    bdiv  = 16'd4;
    write_byte(8'hFF);
    k = cyc;
    wait_until(k + 4);
    check("div_start1_end", 32'(tx), 32'd0);
    wait_until(k + 5);
    check("div_data1_first", 32'(tx), 32'd1);
    bdiv = 16'd8;
    write_byte(8'hFF);
    wait_until(k + 40);
    check("div_stop1_last", 32'(tx), 32'd1);
    wait_until(k + 41);
    check("div_start2_first", 32'(tx), 32'd0);
    wait_until(k + 48);
    check("div_start2_last", 32'(tx), 32'd0);
    wait_until(k + 49);
    check("div_data2_first", 32'(tx), 32'd1);
    wait_idle(200, "div_idle");

    // Reset during data bit 3 with another byte queued
    bdiv = 16'd4;
    write_byte(8'h00);
    s = cyc + 1;
    write_byte(8'hA5);
    wait_until(s + 17);
    check("rst_in_data", 32'(tx), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("rst_quiet_cycles_bad", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Transmit-only 8N1 UART: byte writes go into a small synchronous FIFO; a shift engine serialises them onto `tx`.
- Bit period is set at run time by a clock-cycle divisor (`bdiv`).
- Sits between a CPU/bus write port and the board serial pin.
- Single clock domain; no receiver.

Parameters:
- FIFO_DEPTH, 4, number of queued bytes (power of two, >= 2).
- DIV_W, 16, width of the bdiv divisor input.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wdata  input  8  byte to transmit.
- we  input  1  write strobe; a byte is enqueued on every rising edge with we=1 and full=0.
- bdiv  input  DIV_W  clock cycles per serial bit (e.g. 434 at 50 MHz gives 115200 baud).
- tx  output  1  serial line, idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in flight.
- full  output  1  FIFO cannot accept a write this cycle.

Behaviour:
- Reset (sampled on clk edge): tx=1, busy=0, full=0, FIFO pointers/count=0, engine IDLE, divisor counter=0.
- Reset mid-frame aborts the frame; tx is 1 after that edge; queued bytes are discarded.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Frame length is 10 bit periods.
- Bit period = bdiv clock cycles. bdiv=0 is treated as 1.
- bdiv is latched at frame start, so changing it mid-frame affects only later frames.
- FIFO write: we && !full at edge k enqueues wdata. we while full is silently dropped; no state changes.
- Simultaneous enqueue and dequeue in one cycle is legal; the count is unchanged. When full, a write in the same cycle as a pop is still dropped, because full is the registered pre-edge value.
- full = (count == FIFO_DEPTH), registered.
- busy is a combinational OR of (count != 0) and (state != IDLE).
- Engine states:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, latch bdiv, clear the bit counter, go to START.
  - START: tx=0 for one bit period, then DATA.
  - DATA: tx = shift[0]; shift right each bit period; after 8 bits go to STOP.
  - STOP: tx=1 for one bit period. At its final cycle, if the FIFO is non-empty, pop and enter START directly (no idle gap); otherwise go to IDLE.
- Latency: byte written at edge k into an empty FIFO with engine idle → pop at edge k+1 → tx=0 from edge k+1. The start bit lasts exactly bdiv cycles.
- tx is driven from a register (glitch-free).
- Divisor counter runs 0..bdiv_latched-1 and wraps; the bit advances on wrap.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, STOP)
  - constants DATA_BITS=8, IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1
- Sub-module uart_tx_fifo: synchronous FIFO with the same clk and reset; ports push/pop/din/dout/count/full/empty.
- Top-level uart_tx holds the divisor, the engine FSM and the shift register.

Test Plan:
- Reset held 2 cycles, then released with we=0 → tx=1, busy=0, full=0 for 1000 cycles.
- bdiv=434, single write 8'h41 ('A') → tx sequence 0,1,0,0,0,0,0,1,0,1. Each level lasts 434 cycles; start is at write edge+1; busy drops 4340 cycles after the pop.
- bdiv=434, wdata='A', we held high from reset release → FIFO fills (full=1 within 6 cycles). Consecutive 'A' frames repeat every 4340 cycles with no idle gap; 11 complete frames occur in 50000 cycles; tx is never high for more than 1 bit period between frames.
- bdiv=4, writes 8'h00 then 8'hFF back-to-back → frames 0,0×8,1 then 0,1×8,1, each bit 4 cycles. Writes while full are dropped (verify with a 6-byte burst at depth 4 plus the in-flight byte: exactly 5 frames out).
- bdiv changed from 4 to 8 mid-frame → current frame keeps 4-cycle bits; next frame uses 8.
- Reset asserted during DATA bit 3 → tx=1 the next cycle, busy=0, and no further frames.
